mantissa_pipe_multiplier: RTL

//  Pipelined, parametrised unsigned mantissa multiplier for the FP multiplier datapath.

---
 rtl/mant_mul_pkg.sv | 14 +
 rtl/mant_mul_stage.sv | 103 ++++++++++
 rtl/mantissa_pipe_multiplier.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mant_mul_pkg.sv
// Shared constants and sizing helpers for the pipelined mantissa multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mant_mul_pkg;

  localparam int SP_MANT_W = 24;  // single precision incl. hidden bit
  localparam int DP_MANT_W = 53;  // double precision incl. hidden bit

  // Partial-product rows summed per pipeline stage: ceil(w/s).
  function automatic int pp_per_stage(input int w, input int s);
    return (w + s - 1) / s;
  endfunction

endpackage

// File: rtl/mant_mul_stage.sv
// One pipeline stage: adds its slice of partial-product rows into the running accumulator.
// Latency: 1 cycle (registered output).
// Backpressure: loads only when adv is high; otherwise holds its contents.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   adv                     this stage's register may load (downstream empty or advancing)
//   up_vld/acc/a/b/tag      contents arriving from the previous stage (or the input port)
//   vld/acc/a/b/tag         registered contents of this stage
//   acc_nxt                 combinational sum about to be registered
//   load                    a valid item is being captured this cycle
module mant_mul_stage
  import mant_mul_pkg::*;
#(
  parameter int MANT_W = SP_MANT_W,
  parameter int TAG_W  = 8,
  parameter int STAGES = 4,
  parameter int IDX    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adv,
  input  logic                up_vld,
  input  logic [2*MANT_W-1:0] up_acc,
  input  logic [MANT_W-1:0]   up_a,
  input  logic [MANT_W-1:0]   up_b,
  input  logic [TAG_W-1:0]    up_tag,
  output logic                vld,
  output logic [2*MANT_W-1:0] acc,
  output logic [MANT_W-1:0]   a,
  output logic [MANT_W-1:0]   b,
  output logic [TAG_W-1:0]    tag,
  output logic [2*MANT_W-1:0] acc_nxt,
  output logic                load
);

  localparam int PPS = pp_per_stage(MANT_W, STAGES);
  localparam int LO  = IDX * PPS;
  // Trailing stages may own fewer rows, or none when STAGES does not divide MANT_W.
  localparam int HI  = (LO + PPS > MANT_W) ? MANT_W : LO + PPS;

  logic [2*MANT_W-1:0] a_ext;

  logic                vld_q, vld_d;
  logic [2*MANT_W-1:0] acc_q, acc_d;
  logic [MANT_W-1:0]   a_q, a_d;
  logic [MANT_W-1:0]   b_q, b_d;
  logic [TAG_W-1:0]    tag_q, tag_d;

  assign a_ext = {{MANT_W{1'b0}}, up_a};

  // Row adder: row i = b[i] ? a << i : 0. The full product fits in 2*MANT_W bits,
  // so truncating the sum never loses a carry.
  always_comb begin
    acc_nxt = up_acc;
    for (int i = LO; i < HI; i++) begin
      if (up_b[i]) acc_nxt = acc_nxt + (a_ext << i);
    end
  end

  assign load = adv && up_vld;

  // Data is only captured alongside a valid item; bubbles move the valid bit alone.
  always_comb begin
    vld_d = vld_q;
    acc_d = acc_q;
    a_d   = a_q;
    b_d   = b_q;
    tag_d = tag_q;
    if (adv) begin
      vld_d = up_vld;
      if (up_vld) begin
        acc_d = acc_nxt;
        a_d   = up_a;
        b_d   = up_b;
        tag_d = up_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      tag_q <= '0;
    end else begin
      vld_q <= vld_d;
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      tag_q <= tag_d;
    end
  end

  assign vld = vld_q;
  assign acc = acc_q;
  assign a   = a_q;
  assign b   = b_q;
  assign tag = tag_q;

endmodule

// File: rtl/mantissa_pipe_multiplier.sv
// Pipelined unsigned mantissa multiplier (2*MANT_W-bit product) with tag sideband.
// Latency: STAGES cycles from accepted input to out_valid when not stalled; 1 result/cycle.
// Backpressure: out_valid && !out_ready stalls; bubbles collapse; in_ready is combinational
//               from out_ready through the stage valid bits.
//
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_a/in_b/in_tag operand side;
//        out_valid/out_ready/out_prod/out_tag product side.
// Optional macro MANT_MUL_NORM_EN adds norm_mant/norm_shift/norm_guard/norm_sticky,
// registered together with out_prod.
module mantissa_pipe_multiplier
  import mant_mul_pkg::*;
#(
  parameter int MANT_W = SP_MANT_W,
  parameter int STAGES = 4,
  parameter int TAG_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MANT_W-1:0]   in_a,
  input  logic [MANT_W-1:0]   in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*MANT_W-1:0] out_prod,
  output logic [TAG_W-1:0]    out_tag
`ifdef MANT_MUL_NORM_EN
  ,
  output logic [MANT_W-1:0]   norm_mant,
  output logic                norm_shift,
  output logic                norm_guard,
  output logic                norm_sticky
`endif
);

  // Element 0 is the input port; element k+1 is the register of stage k.
  logic                vld_c [STAGES+1];
  logic [2*MANT_W-1:0] acc_c [STAGES+1];
  logic [MANT_W-1:0]   a_c   [STAGES+1];
  logic [MANT_W-1:0]   b_c   [STAGES+1];
  logic [TAG_W-1:0]    tag_c [STAGES+1];

  logic [STAGES-1:0][2*MANT_W-1:0] acc_nxt_c;
  logic [STAGES-1:0]               load_c;
  logic [STAGES-1:0]               adv;

  assign vld_c[0] = in_valid;
  assign acc_c[0] = '0;
  assign a_c[0]   = in_a;
  assign b_c[0]   = in_b;
  assign tag_c[0] = in_tag;

  // Stage k may load iff some register at or after it is empty, or the output is taken.
  // Written flat over the registered valid bits so there is no combinational chain
  // through adv itself.
  always_comb begin
    adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      adv[k] = out_ready;
      for (int j = k + 1; j <= STAGES; j++) begin
        adv[k] = adv[k] || !vld_c[j];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    mant_mul_stage #(
      .MANT_W (MANT_W),
      .TAG_W  (TAG_W),
      .STAGES (STAGES),
      .IDX    (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .adv     (adv[k]),
      .up_vld  (vld_c[k]),
      .up_acc  (acc_c[k]),
      .up_a    (a_c[k]),
      .up_b    (b_c[k]),
      .up_tag  (tag_c[k]),
      .vld     (vld_c[k+1]),
      .acc     (acc_c[k+1]),
      .a       (a_c[k+1]),
      .b       (b_c[k+1]),
      .tag     (tag_c[k+1]),
      .acc_nxt (acc_nxt_c[k]),
      .load    (load_c[k])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_c[STAGES];
  assign out_prod  = acc_c[STAGES];
  assign out_tag   = tag_c[STAGES];

  // Operands leaving the last stage and per-stage sums/loads are not needed downstream.
  logic unused_tail;
  assign unused_tail = ^{a_c[STAGES], b_c[STAGES], acc_nxt_c, load_c};

`ifdef MANT_MUL_NORM_EN
  logic [2*MANT_W-1:0] p_nxt;
  logic [MANT_W-1:0]   norm_mant_q, norm_mant_d;
  logic                norm_shift_q, norm_shift_d;
  logic                norm_guard_q, norm_guard_d;
  logic                norm_sticky_q, norm_sticky_d;

  assign p_nxt = acc_nxt_c[STAGES-1];

  // Computed from the last stage's sum so it lands in the same cycle as out_prod.
  always_comb begin
    norm_mant_d   = norm_mant_q;
    norm_shift_d  = norm_shift_q;
    norm_guard_d  = norm_guard_q;
    norm_sticky_d = norm_sticky_q;
    if (load_c[STAGES-1]) begin
      if (p_nxt[2*MANT_W-1]) begin
        norm_mant_d   = p_nxt[2*MANT_W-1:MANT_W];
        norm_shift_d  = 1'b1;
        norm_guard_d  = p_nxt[MANT_W-1];
        norm_sticky_d = |p_nxt[MANT_W-2:0];
      end else begin
        norm_mant_d   = p_nxt[2*MANT_W-2:MANT_W-1];
        norm_shift_d  = 1'b0;
        norm_guard_d  = p_nxt[MANT_W-2];
        norm_sticky_d = |p_nxt[MANT_W-3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      norm_mant_q   <= '0;
      norm_shift_q  <= 1'b0;
      norm_guard_q  <= 1'b0;
      norm_sticky_q <= 1'b0;
    end else begin
      norm_mant_q   <= norm_mant_d;
      norm_shift_q  <= norm_shift_d;
      norm_guard_q  <= norm_guard_d;
      norm_sticky_q <= norm_sticky_d;
    end
  end

  assign norm_mant   = norm_mant_q;
  assign norm_shift  = norm_shift_q;
  assign norm_guard  = norm_guard_q;
  assign norm_sticky = norm_sticky_q;
`endif

endmodule
